// File: rtl/board_input_conditioner_pkg.sv
// Shared constants for the board input conditioner: button roles and default timing.
package board_pkg;

    localparam int BTN_COUNT = 6;
    localparam int BTN_RST   = 0;
    localparam int BTN_STEP  = 1;
    localparam int BTN_PAGE  = 5;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_RUN_DIV         = 50000000;
    localparam int DEF_PAGE_COUNT      = 8;

    typedef enum logic {
        SRC_MANUAL = 1'b0,
        SRC_RUN    = 1'b1
    } step_src_e;

endpackage

// File: rtl/board_input_conditioner_btn_debounce.sv
// One push-button lane: two-flop synchroniser, stability counter and rise detector.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic rise_next
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          prev_q, prev_d;
    logic          rise_q, rise_d;

    // A level flip needs DEBOUNCE_CYCLES consecutive differing samples; any agreeing sample restarts the count.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        prev_d  = level_q;
        rise_d  = level_q & ~prev_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
        end
    end

    assign level     = level_q;
    assign rise      = rise_q;
    assign rise_next = rise_d;

endmodule

// File: rtl/board_input_conditioner.sv
// Debounces the six board buttons and derives the CPU step clock, step counter and display page.
module board_input_conditioner
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PAGE_COUNT      = DEF_PAGE_COUNT,
    parameter int RUN_DIV         = DEF_RUN_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  swb,
    input  logic        run_en,
    output logic [5:0]  btn_level,
    output logic [5:0]  btn_rise,
    output logic        cpu_rst,
    output logic        cpu_clk,
    output logic [2:0]  page,
    output logic [15:0] step_count
);

    localparam int DW = $clog2(RUN_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RUN_DIV - 1);
    localparam logic [2:0]    PAGE_LAST = 3'(PAGE_COUNT - 1);

    logic [BTN_COUNT-1:0] rise_next;
    logic                 unused_rise_next;

    for (genvar i = 0; i < BTN_COUNT; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk       (clk),
            .rst       (rst),
            .raw       (swb[i]),
            .level     (btn_level[i]),
            .rise      (btn_rise[i]),
            .rise_next (rise_next[i])
        );
    end

    assign unused_rise_next = ^{rise_next[4:2], rise_next[0]};

    logic          run_s1_q, run_s1_d;
    logic          run_s2_q, run_s2_d;
    logic [DW-1:0] div_q, div_d;
    logic          cpu_clk_q, cpu_clk_d;
    logic [15:0]   step_count_q, step_count_d;
    logic [2:0]    page_q, page_d;
    step_src_e     step_src;
    logic          run_tick;
    logic          tick;

    // Ticks use the same-cycle rise so cpu_clk moves on the edge btn_rise is raised; the divider sits at zero outside run mode.
    always_comb begin
        run_s1_d     = run_en;
        run_s2_d     = run_s1_q;
        step_src     = run_s2_q ? SRC_RUN : SRC_MANUAL;
        run_tick     = 1'b0;
        div_d        = '0;
        if (step_src == SRC_RUN) begin
            run_tick = (div_q == DIV_LAST);
            div_d    = run_tick ? '0 : div_q + 1'b1;
        end
        tick         = (step_src == SRC_RUN) ? run_tick : rise_next[BTN_STEP];
        cpu_clk_d    = cpu_clk_q;
        step_count_d = step_count_q;
        if (tick && !btn_level[BTN_RST]) begin
            cpu_clk_d = ~cpu_clk_q;
            if (!cpu_clk_q) begin
                step_count_d = step_count_q + 16'd1;
            end
        end
        page_d       = page_q;
        if (rise_next[BTN_PAGE]) begin
            page_d = (page_q == PAGE_LAST) ? 3'd0 : page_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_s1_q     <= 1'b0;
            run_s2_q     <= 1'b0;
            div_q        <= '0;
            cpu_clk_q    <= 1'b0;
            step_count_q <= 16'd0;
            page_q       <= 3'd0;
        end else begin
            run_s1_q     <= run_s1_d;
            run_s2_q     <= run_s2_d;
            div_q        <= div_d;
            cpu_clk_q    <= cpu_clk_d;
            step_count_q <= step_count_d;
            page_q       <= page_d;
        end
    end

    assign cpu_rst    = btn_level[BTN_RST];
    assign cpu_clk    = cpu_clk_q;
    assign page       = page_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner with short debounce and run-divider settings.
module tb_board_input_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  swb;
    logic        run_en;
    logic [5:0]  btn_level;
    logic [5:0]  btn_rise;
    logic        cpu_rst;
    logic        cpu_clk;
    logic [2:0]  page;
    logic [15:0] step_count;

    int n_cmp  = 0;
    int n_fail = 0;

    board_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .PAGE_COUNT      (8),
        .RUN_DIV         (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .swb        (swb),
        .run_en     (run_en),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .cpu_rst    (cpu_rst),
        .cpu_clk    (cpu_clk),
        .page       (page),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic [5:0] s, input logic re);
        rst    = r;
        swb    = s;
        run_en = re;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       exp_clk;
        logic [2:0] exp_page;
        logic [0:3] man_clk;
        int         man_cnt [4];

        // Reset held with every button pressed
        applyStimulus(1'b0, 6'h3F, 1'b0);
        step(3);
        checkOutput("rst_level", 16'(btn_level), 16'h0000);
        checkOutput("rst_rise", 16'(btn_rise), 16'h0000);
        checkOutput("rst_cpu_clk", 16'(cpu_clk), 16'h0000);
        checkOutput("rst_page", 16'(page), 16'h0000);
        checkOutput("rst_step_count", step_count, 16'h0000);
        checkOutput("rst_cpu_rst", 16'(cpu_rst), 16'h0000);
        applyStimulus(1'b1, 6'h3F, 1'b0);
        step(5);
        checkOutput("deb_level_early", 16'(btn_level), 16'h0000);
        step(1);
        checkOutput("deb_level_6", 16'(btn_level), 16'h003F);
        checkOutput("deb_rise_6", 16'(btn_rise), 16'h0000);
        step(1);
        checkOutput("deb_rise_7", 16'(btn_rise), 16'h003F);
        checkOutput("deb_cpu_clk_gated", 16'(cpu_clk), 16'h0000);
        checkOutput("deb_page_7", 16'(page), 16'h0001);
        step(1);
        checkOutput("deb_rise_8", 16'(btn_rise), 16'h0000);
        applyStimulus(1'b1, 6'h00, 1'b0);
        step(8);
        checkOutput("rel_level", 16'(btn_level), 16'h0000);
        checkOutput("rel_rise", 16'(btn_rise), 16'h0000);
        checkOutput("rel_page", 16'(page), 16'h0001);

        // Three-sample glitch on the reset and step buttons
        applyStimulus(1'b1, 6'h03, 1'b0);
        step(3);
        applyStimulus(1'b1, 6'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1);
            checkOutput("glitch_level", 16'(btn_level), 16'h0000);
            checkOutput("glitch_rise", 16'(btn_rise), 16'h0000);
        end
        checkOutput("glitch_cpu_clk", 16'(cpu_clk), 16'h0000);

        // Manual stepping
        man_clk = 4'b1010;
        man_cnt = '{1, 1, 2, 2};
        exp_clk = 1'b0;
        for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b1, 6'h02, 1'b0);
            step(6);
            checkOutput("man_clk_before", 16'(cpu_clk), 16'(exp_clk));
            step(1);
            exp_clk = man_clk[p];
            checkOutput("man_clk_at7", 16'(cpu_clk), 16'(exp_clk));
            checkOutput("man_step_count", step_count, 16'(man_cnt[p]));
            checkOutput("man_rise", 16'(btn_rise), 16'h0002);
            applyStimulus(1'b1, 6'h00, 1'b0);
            step(8);
        end

        // Free-run mode with the step button held
        applyStimulus(1'b1, 6'h02, 1'b1);
        exp_clk = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            if (k == 7 || k == 12 || k == 17 || k == 22) exp_clk = ~exp_clk;
            checkOutput("run_cpu_clk", 16'(cpu_clk), 16'(exp_clk));
            if (k == 22) applyStimulus(1'b1, 6'h02, 1'b0);
        end
        checkOutput("run_step_count", step_count, 16'h0004);
        applyStimulus(1'b1, 6'h02, 1'b1);
        step(6);
        checkOutput("rerun_clk_before", 16'(cpu_clk), 16'h0000);
        step(1);
        checkOutput("rerun_clk_at7", 16'(cpu_clk), 16'h0001);
        checkOutput("rerun_step_count", step_count, 16'h0005);
        applyStimulus(1'b1, 6'h00, 1'b0);
        step(12);
        checkOutput("runoff_cpu_clk", 16'(cpu_clk), 16'h0001);
        checkOutput("runoff_step_count", step_count, 16'h0005);

        // Second reset, then page wrap with a simultaneous step on the first press
        applyStimulus(1'b0, 6'h00, 1'b0);
        step(2);
        checkOutput("rst2_cpu_clk", 16'(cpu_clk), 16'h0000);
        checkOutput("rst2_page", 16'(page), 16'h0000);
        checkOutput("rst2_step_count", step_count, 16'h0000);
        applyStimulus(1'b1, 6'h00, 1'b0);
        exp_page = 3'd0;
        for (int n = 0; n < 9; n++) begin
            applyStimulus(1'b1, (n == 0) ? 6'h22 : 6'h20, 1'b0);
            step(7);
            exp_page = (exp_page == 3'd7) ? 3'd0 : exp_page + 3'd1;
            checkOutput("page_value", 16'(page), 16'(exp_page));
            if (n == 0) begin
                checkOutput("page_step_clk", 16'(cpu_clk), 16'h0001);
                checkOutput("page_step_count", step_count, 16'h0001);
            end
            applyStimulus(1'b1, 6'h00, 1'b0);
            step(8);
        end

        // CPU held in reset ignores step presses
        applyStimulus(1'b1, 6'h01, 1'b0);
        step(8);
        checkOutput("gate_cpu_rst", 16'(cpu_rst), 16'h0001);
        applyStimulus(1'b1, 6'h03, 1'b0);
        step(7);
        checkOutput("gate_cpu_clk", 16'(cpu_clk), 16'h0001);
        checkOutput("gate_step_count", step_count, 16'h0001);
        applyStimulus(1'b1, 6'h01, 1'b0);
        step(8);
        checkOutput("gate_cpu_clk_after", 16'(cpu_clk), 16'h0001);
        applyStimulus(1'b1, 6'h00, 1'b0);
        step(8);
        checkOutput("gate_cpu_rst_off", 16'(cpu_rst), 16'h0000);

        // Step counter wrap from 0xFFFF
        applyStimulus(1'b1, 6'h02, 1'b0);
        step(7);
        checkOutput("wrap_fall_clk", 16'(cpu_clk), 16'h0000);
        checkOutput("wrap_fall_count", step_count, 16'h0001);
        applyStimulus(1'b1, 6'h00, 1'b0);
        step(8);
        force dut.step_count_q = 16'hFFFF;
        step(1);
        release dut.step_count_q;
        step(1);
        checkOutput("wrap_preload", step_count, 16'hFFFF);
        applyStimulus(1'b1, 6'h02, 1'b0);
        step(7);
        checkOutput("wrap_clk", 16'(cpu_clk), 16'h0001);
        checkOutput("wrap_count", step_count, 16'h0000);
        applyStimulus(1'b1, 6'h00, 1'b0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
